// File: rtl/multicycle_datapath.sv
// -----------------------------------------------------------------------------
// multicycle_datapath
//
// Datapath and FSM state register of the multicycle MIPS32 core. Holds the
// architectural PC, the internal IR/MDR/A/B/ALUOut registers, the 32x32
// register file, the ALU with its funct decoder and the 4-bit control state.
// The combinational control logic lives outside this block: it reads `state`
// and `opcode` and returns the per-cycle strobes.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset, clears every register
//   next_state   next control state, loaded every cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   AluSrcA, RegWrite, RegDst          single-bit control strobes
//   PCSrc, AluOp, AluSrcB              2-bit control selects
//   state        current control state
//   opcode       IR[31:26]
//   mem_addr     unified memory address (ALUOut for data, PC for fetch)
//   mem_wdata    store data (B)
//   mem_read     MemRead pass-through (combinational)
//   mem_write    MemWrite pass-through (combinational)
//   mem_rdata    combinational memory read data for mem_addr
// -----------------------------------------------------------------------------
module multicycle_datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  next_state,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic        IorD,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        IRWrite,
    input  logic        MemtoReg,
    input  logic        AluSrcA,
    input  logic        RegWrite,
    input  logic        RegDst,
    input  logic [1:0]  PCSrc,
    input  logic [1:0]  AluOp,
    input  logic [1:0]  AluSrcB,
    output logic [3:0]  state,
    output logic [5:0]  opcode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_ctl_e;

    // Architectural and internal registers
    logic [31:0] pc_r;
    logic [31:0] ir_r;
    logic [31:0] mdr_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] aluout_r;
    logic [31:0] regs_r [0:31];
    logic [3:0]  state_r;

    // Combinational datapath signals
    logic [31:0] rs_data_s;
    logic [31:0] rt_data_s;
    logic [31:0] sext_imm_s;
    logic [31:0] alu_a_s;
    logic [31:0] alu_b_s;
    logic [31:0] alu_result_s;
    logic [31:0] pc_next_s;
    logic [31:0] wr_data_s;
    logic [4:0]  wr_addr_s;
    logic        zero_s;
    logic        pc_en_s;
    alu_ctl_e    alu_ctl_s;

    // Output map: everything except the memory strobes comes from registers
    assign state     = state_r;
    assign opcode    = ir_r[31:26];
    assign mem_addr  = IorD ? aluout_r : pc_r;
    assign mem_wdata = b_r;
    assign mem_read  = MemRead;
    assign mem_write = MemWrite;

    assign sext_imm_s = {{16{ir_r[15]}}, ir_r[15:0]};
    assign wr_addr_s  = RegDst ? ir_r[15:11] : ir_r[20:16];
    assign wr_data_s  = MemtoReg ? mdr_r : aluout_r;
    assign alu_a_s    = AluSrcA ? a_r : pc_r;
    assign zero_s     = (alu_result_s == 32'd0);
    assign pc_en_s    = PCWrite | (PCWriteCond & zero_s);

    // Register file read ports; register 0 is hard-wired to zero
    always_comb begin
        rs_data_s = 32'd0;
        rt_data_s = 32'd0;
        if (ir_r[25:21] != 5'd0) begin
            rs_data_s = regs_r[ir_r[25:21]];
        end else begin
            rs_data_s = 32'd0;
        end
        if (ir_r[20:16] != 5'd0) begin
            rt_data_s = regs_r[ir_r[20:16]];
        end else begin
            rt_data_s = 32'd0;
        end
    end

    // ALU operand B select
    always_comb begin
        alu_b_s = b_r;
        case (AluSrcB)
            2'b00:   alu_b_s = b_r;
            2'b01:   alu_b_s = 32'd4;
            2'b10:   alu_b_s = sext_imm_s;
            2'b11:   alu_b_s = {sext_imm_s[29:0], 2'b00};
            default: alu_b_s = b_r;
        endcase
    end

    // ALU control: AluOp 10 defers to the R-type funct field, unknown -> add
    always_comb begin
        alu_ctl_s = ALU_ADD;
        case (AluOp)
            2'b00: alu_ctl_s = ALU_ADD;
            2'b01: alu_ctl_s = ALU_SUB;
            2'b10: begin
                case (ir_r[5:0])
                    6'h20:   alu_ctl_s = ALU_ADD;
                    6'h22:   alu_ctl_s = ALU_SUB;
                    6'h24:   alu_ctl_s = ALU_AND;
                    6'h25:   alu_ctl_s = ALU_OR;
                    6'h2A:   alu_ctl_s = ALU_SLT;
                    default: alu_ctl_s = ALU_ADD;
                endcase
            end
            default: alu_ctl_s = ALU_ADD;
        endcase
    end

    // ALU: 32-bit wrap-around arithmetic, signed set-less-than
    always_comb begin
        alu_result_s = 32'd0;
        case (alu_ctl_s)
            ALU_ADD: alu_result_s = alu_a_s + alu_b_s;
            ALU_SUB: alu_result_s = alu_a_s - alu_b_s;
            ALU_AND: alu_result_s = alu_a_s & alu_b_s;
            ALU_OR:  alu_result_s = alu_a_s | alu_b_s;
            ALU_SLT: alu_result_s = {31'd0, ($signed(alu_a_s) < $signed(alu_b_s))};
            default: alu_result_s = alu_a_s + alu_b_s;
        endcase
    end

    // Next-PC select; PCSrc 11 falls back to the live ALU result
    always_comb begin
        pc_next_s = alu_result_s;
        case (PCSrc)
            2'b00:   pc_next_s = alu_result_s;
            2'b01:   pc_next_s = aluout_r;
            2'b10:   pc_next_s = {pc_r[31:28], ir_r[25:0], 2'b00};
            default: pc_next_s = alu_result_s;
        endcase
    end

    // PC, IR and the free-running internal registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r     <= 32'd0;
            ir_r     <= 32'd0;
            mdr_r    <= 32'd0;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            aluout_r <= 32'd0;
        end else begin
            if (pc_en_s) begin
                pc_r <= pc_next_s;
            end
            if (IRWrite) begin
                ir_r <= mem_rdata;
            end
            mdr_r    <= mem_rdata;
            a_r      <= rs_data_s;
            b_r      <= rt_data_s;
            aluout_r <= alu_result_s;
        end
    end

    // Register file write port; A/B see the old value on a same-edge write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i[4:0]] <= 32'd0;
            end
        end else if (RegWrite && (wr_addr_s != 5'd0)) begin
            regs_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= 4'd0;
        end else begin
            state_r <= next_state;
        end
    end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Datapath and state register for the multicycle MIPS core. The block holds the PC, IR, MDR, A, B, ALUOut, the 32x32 register file, the ALU with its funct decoder, and the 4-bit FSM state register. It consumes the per-cycle control strobes from the combinational control logic and returns `state` and `opcode` to that logic. It also drives the single unified memory port.

## Interface
No parameters: all widths are fixed to MIPS32.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- next_state  in  4  next FSM state from control logic
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, AluSrcA, RegWrite, RegDst  in  1 each  control strobes
- PCSrc, AluOp, AluSrcB  in  2 each  control selects
- state  out  4  current FSM state
- opcode  out  6  IR[31:26]
- mem_addr  out  32  memory address
- mem_wdata  out  32  store data
- mem_read, mem_write  out  1  pass-through of MemRead and MemWrite
- mem_rdata  in  32  combinational memory read data, valid in the same cycle as mem_addr

## Operation
- Memory port: mem_addr = IorD ? ALUOut : PC. mem_wdata = B.
- IR loads mem_rdata only when IRWrite=1. MDR loads mem_rdata every cycle.
- Register file: rs = IR[25:21], rt = IR[20:16], rd = IR[15:11]. Reads are combinational.
- A and B load the rs and rt read data every cycle.
- Register write:
  - Write address = RegDst ? rd : rt.
  - Write data = MemtoReg ? MDR : ALUOut.
  - Writes on a clock edge when RegWrite=1.
  - Writes to register 0 are discarded; register 0 always reads 0.
- ALU operand A: AluSrcA ? A : PC.
- ALU operand B by AluSrcB:
  - 00: B
  - 01: 32'd4
  - 10: sign-extended IR[15:0]
  - 11: sign-extended IR[15:0] << 2
- ALU operation:
  - AluOp 00: add. AluOp 01: subtract. AluOp 11: treated as add.
  - AluOp 10 decodes IR[5:0]: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed; result 1 or 0). Any other funct: add.
- ALU arithmetic is 32-bit wrap-around with no overflow trap.
- zero = (ALU result == 0).
- ALUOut loads the ALU result every cycle.
- PC source by PCSrc:
  - 00: ALU result
  - 01: ALUOut
  - 10: {PC[31:28], IR[25:0], 2'b00}
  - 11: treated as 00.
- PC loads when PCWrite | (PCWriteCond & zero).
- state loads next_state every cycle.

## Timing
- Reset, in the cycle it is asserted: PC, IR, MDR, A, B, ALUOut, all 32 registers and state are cleared to 0. Reset overrides every write enable.
- Reset outputs:
  - state = 0, opcode = 0, mem_addr = 0, mem_wdata = 0.
  - mem_read and mem_write follow the control inputs combinationally.
- Reset mid-instruction: the next cycle is a fetch from address 0. No partial register-file or memory write happens in the reset cycle.
- All register updates occur on the rising edge. All outputs are registered-value functions, except mem_read and mem_write, which are combinational.
- Register-file read-during-write, same edge: A and B capture the old value, and the new value is visible from the next cycle.
- Branch: PC loads in the same edge that zero is evaluated, in state 8. ALUOut holds the target computed in state 1.
- Instruction latencies from fetch to the first fetch of the next instruction:
  - R-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles

## Test plan
- lw: mem[0] = lw $t0, 8($0) (0x8C080008), mem[8] = 0xDEADBEEF. Run with the control logic → $t0 = 0xDEADBEEF after 5 cycles, PC = 4.
- R-type: $1 = 7, $2 = 5. Run add $3,$1,$2, sub $4,$1,$2 and slt $5,$2,$1 → $3 = 12, $4 = 2, $5 = 1. Also run add $0,$1,$2 → $0 stays 0.
- sw: $1 = 0x12345678. Run sw $1, 16($0) → mem_write is high for exactly one cycle with mem_addr = 16 and mem_wdata = 0x12345678.
- beq: $1 = $2, beq at PC 0 with offset 3 → PC = 16 after 3 cycles. With $1 ≠ $2 → PC = 4.
- j: j 0x40 (0x08000040) at PC 0 → PC = 0x100.
- Reset: assert reset in the MDR-write state of a lw → state = 0, PC = 0, target register unchanged (0). The next cycle fetches address 0.
